q_sys_msgdma_write_burst_master: RTL and testbench
==================================================

// Module: q_sys_msgdma_write_burst_master
// PURPOSE
//  Write-side burst master for the mSGDMA datapath. Sits directly downstream of the 256-bit timing adapter FIFO.
//  Takes one write descriptor (address, byte length) and drains FIFO beats into Avalon-MM write bursts.
//  Starts a burst only when the FIFO fill level covers the whole burst, so bursts never starve on data.
// PARAMETERS
//  DATA_WIDTH  256  stream/memory data width; bytes per beat BPB = DATA_WIDTH/8 = 32
//  ADDR_WIDTH  32   byte address width
//  LEN_WIDTH   24   descriptor length width, in bytes
//  BURST_MAX   4    maximum avm_burstcount; must be <= FIFO DEPTH (8)
//  FILL_WIDTH  4    width of the fill_level input from the FIFO
// PORTS
//  clk             in   1           clock
//  reset_n         in   1           asynchronous, active-low reset
//  desc_valid      in   1           descriptor offered
//  desc_ready      out  1           descriptor accepted on desc_valid&&desc_ready
//  desc_address    in   ADDR_WIDTH  start byte address; low log2(BPB) bits ignored (forced 0)
//  desc_length     in   LEN_WIDTH   byte count; low log2(BPB) bits ignored (whole beats only)
//  in_valid        in   1           FIFO out_valid
//  in_ready        out  1           pop FIFO; beat consumed on in_valid&&in_ready
//  in_data         in   DATA_WIDTH  FIFO out_data
//  fill_level      in   FILL_WIDTH  FIFO occupancy, in beats
//  avm_address     out  ADDR_WIDTH  burst start byte address
//  avm_write       out  1           write request
//  avm_writedata   out  DATA_WIDTH  = in_data
//  avm_byteenable  out  DATA_WIDTH/8  all ones
//  avm_burstcount  out  3           beats in the current burst (1..BURST_MAX)
//  avm_waitrequest in   1           slave stall
//  busy            out  1           descriptor in progress (state != IDLE)
//  done            out  1           one-cycle pulse when the descriptor completes
// BEHAVIOUR
//  Reset values: desc_ready=0, in_ready=0, avm_write=0, avm_address=0, avm_burstcount=0, busy=0, done=0.
//  Internal regs: addr, beats_left = desc_length>>log2(BPB), burst_len, beat_cnt.
//  FSM IDLE -> WAIT_DATA -> BURST -> (WAIT_DATA | DONE) -> IDLE.
//  IDLE:
//   - desc_ready is registered: 1 from the first edge after reset release, whenever state is IDLE.
//   - On accept: latch addr and beats_left.
//   - beats_left==0 -> DONE; else -> WAIT_DATA.
//  WAIT_DATA:
//   - b = min(BURST_MAX, beats_left).
//   - If fill_level >= b: register avm_burstcount=b and avm_address=addr, then -> BURST. Otherwise hold.
//  BURST:
//   - Outputs: avm_write = in_valid; in_ready = in_valid && !avm_waitrequest; avm_writedata = in_data.
//   - A beat transfers when avm_write && !avm_waitrequest; the FIFO pops in the same cycle.
//   - in_valid low mid-burst deasserts avm_write; address and burstcount are held, burst resumes.
//   - avm_address and avm_burstcount are constant for the whole burst.
//   - On the last beat (beat_cnt==b-1 and transferring): addr += b*BPB, beats_left -= b.
//     If beats_left becomes 0 -> DONE; else -> WAIT_DATA.
//  DONE: done=1 for exactly one cycle, desc_ready=0, then -> IDLE.
//  Outside BURST: avm_write=0 and in_ready=0.
//  Latency: descriptor accepted at edge N -> WAIT_DATA in cycle N+1 -> earliest avm_write in cycle N+2.
//  Address arithmetic wraps modulo 2^ADDR_WIDTH. No 4 KB boundary splitting.
//  Reset mid-operation: FSM returns to IDLE immediately and all outputs take reset values.
//   The partial burst is abandoned; the FIFO contents are the FIFO's own concern.
//  Back-to-back descriptors: the next accept is possible no earlier than the cycle after done.
// TESTING
//  1) FIFO holds 8 beats; desc addr=0x1000, len=128.
//     -> one burst, burstcount=4, address 0x1000, data in order, done pulses once, fill ends at 4.
//  2) len=160, addr=0x2000.
//     -> bursts (4 @0x2000) then (1 @0x2080); 5 beats total, done after the 5th beat.
//  3) avm_waitrequest=1 for 3 cycles on beat 2.
//     -> avm_writedata and address held; no FIFO pop while stalled; 4 beats total, no data loss.
//  4) len=0 -> no avm_write, done pulse 2 cycles after accept, busy low again.
//     len=0x3F -> treated as 1 beat (low bits ignored).
//  5) fill_level=2 with a 4-beat burst pending -> stays in WAIT_DATA, avm_write=0;
//     fill_level reaching 4 -> burst starts the next cycle.
//  6) reset_n low mid-burst (after beat 2) -> outputs 0 immediately, FSM IDLE;
//     after release, a new descriptor runs normally.

Source files
------------

// File: rtl/q_sys_msgdma_write_burst_master.sv
// mSGDMA write-side burst master: turns one (address, length) descriptor into
// Avalon-MM write bursts, launching each burst only once the FIFO holds all of it.
module q_sys_msgdma_write_burst_master #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 24,
    parameter int BURST_MAX  = 4,
    parameter int FILL_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [ADDR_WIDTH-1:0]   desc_address,
    input  logic [LEN_WIDTH-1:0]    desc_length,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [FILL_WIDTH-1:0]   fill_level,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic                    avm_write,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    output logic [2:0]              avm_burstcount,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done
);

    localparam int BPB      = DATA_WIDTH / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int BEATS_W  = LEN_WIDTH - BPB_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_BURST, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEATS_W-1:0]    beats_left_q, beats_left_d;
    logic [2:0]            burst_len_q, burst_len_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] avm_address_q, avm_address_d;
    logic                  desc_ready_q, desc_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [2:0] next_b;
    logic       xfer;
    logic       last_beat;

    // The burst length is frozen in WAIT_DATA, so the slave sees a constant burstcount.
    assign next_b    = (beats_left_q >= BEATS_W'(BURST_MAX)) ? 3'(BURST_MAX) : beats_left_q[2:0];
    assign avm_write = (state_q == S_BURST) && in_valid;
    assign xfer      = avm_write && !avm_waitrequest;
    assign last_beat = xfer && (beat_cnt_q == burst_len_q - 3'd1);

    assign in_ready       = xfer;
    assign avm_writedata  = in_data;
    assign avm_byteenable = '1;
    assign avm_address    = avm_address_q;
    assign avm_burstcount = burst_len_q;
    assign desc_ready     = desc_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beats_left_d  = beats_left_q;
        burst_len_d   = burst_len_q;
        beat_cnt_d    = beat_cnt_q;
        avm_address_d = avm_address_q;
        case (state_q)
            S_IDLE: begin
                if (desc_valid && desc_ready_q) begin
                    addr_d       = desc_address & ~ADDR_WIDTH'(BPB - 1);
                    beats_left_d = BEATS_W'(desc_length >> BPB_LOG2);
                    state_d      = (beats_left_d == '0) ? S_DONE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (fill_level >= FILL_WIDTH'(next_b)) begin
                    avm_address_d = addr_q;
                    burst_len_d   = next_b;
                    beat_cnt_d    = 3'd0;
                    state_d       = S_BURST;
                end
            end
            S_BURST: begin
                if (xfer) beat_cnt_d = beat_cnt_q + 3'd1;
                if (last_beat) begin
                    addr_d       = addr_q + (ADDR_WIDTH'(burst_len_q) << BPB_LOG2);
                    beats_left_d = beats_left_q - BEATS_W'(burst_len_q);
                    state_d      = (beats_left_d == '0) ? S_DONE : S_WAIT_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered from the state being entered.
        desc_ready_d = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            beats_left_q  <= '0;
            burst_len_q   <= '0;
            beat_cnt_q    <= '0;
            avm_address_q <= '0;
            desc_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beats_left_q  <= beats_left_d;
            burst_len_q   <= burst_len_d;
            beat_cnt_q    <= beat_cnt_d;
            avm_address_q <= avm_address_d;
            desc_ready_q  <= desc_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_q_sys_msgdma_write_burst_master.sv
// Scoreboard bench for the write burst master: a queue-backed FIFO model feeds beats,
// descriptors push expected writes, and a negedge monitor pops and compares them.
module tb_q_sys_msgdma_write_burst_master;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         desc_valid = 1'b0;
    logic         desc_ready;
    logic [31:0]  desc_address = '0;
    logic [23:0]  desc_length = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic [3:0]   fill_level = '0;
    logic [31:0]  avm_address;
    logic         avm_write;
    logic [255:0] avm_writedata;
    logic [31:0]  avm_byteenable;
    logic [2:0]   avm_burstcount;
    logic         avm_waitrequest = 1'b0;
    logic         busy;
    logic         done;

    q_sys_msgdma_write_burst_master dut (
        .clk(clk), .reset_n(reset_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_address(desc_address), .desc_length(desc_length),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .fill_level(fill_level),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [2:0]   bc;
        logic [255:0] data;
    } wr_t;

    wr_t          exp_q[$];
    logic [255:0] fifo[$];
    int           push_idx = 0;
    int           claim_idx = 0;
    int           beats_seen = 0;
    int           tests = 0;
    int           failed = 0;

    function automatic logic [255:0] mkdata(input int i);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = 32'hD000_0000 + 32'(i * 16 + w);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model: pops on the edge where the DUT took a beat, then redrives outputs.
    always @(posedge clk) begin
        automatic logic p = in_valid && in_ready;
        #2;
        if (p && fifo.size() > 0) void'(fifo.pop_front());
        in_valid   = (fifo.size() != 0);
        in_data    = (fifo.size() != 0) ? fifo[0] : '0;
        fill_level = 4'(fifo.size());
    end

    // Monitor: every accepted write beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && avm_write && !avm_waitrequest) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got addr %0h expected no write", avm_address);
            end else begin
                automatic wr_t e = exp_q.pop_front();
                chk("wr_addr", 256'(avm_address), 256'(e.addr));
                chk("wr_burstcount", 256'(avm_burstcount), 256'(e.bc));
                chk("wr_data", avm_writedata, e.data);
                chk("wr_pop", 256'(in_ready), 256'(1));
                chk("wr_byteenable", 256'(avm_byteenable), 256'(32'hFFFF_FFFF));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            fifo.push_back(mkdata(push_idx));
            push_idx++;
        end
    endtask

    task automatic send_desc(input logic [31:0] a, input logic [23:0] l);
        int n = 0;
        int beats;
        int b;
        logic [31:0] ad;
        while (!desc_ready && n < 50) begin
            tick;
            n++;
        end
        chk("desc_ready_wait", 256'(desc_ready), 256'(1));
        beats = int'(l) >> 5;
        ad    = a & ~32'h1F;
        while (beats > 0) begin
            b = (beats > 4) ? 4 : beats;
            for (int k = 0; k < b; k++) begin
                exp_q.push_back('{ad, 3'(b), mkdata(claim_idx)});
                claim_idx++;
            end
            ad    = ad + 32'(b * 32);
            beats = beats - b;
        end
        desc_address = a;
        desc_length  = l;
        desc_valid   = 1'b1;
        tick;
        desc_valid   = 1'b0;
    endtask

    task automatic wait_done(input int max, input string nm);
        int n = 0;
        logic got = 1'b0;
        while (n < max && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        chk(nm, 256'(got), 256'(1));
        tick;
        chk("done_one_cycle", 256'(done), 256'(0));
        chk("busy_after_done", 256'(busy), 256'(0));
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_seen < target && n < 100) begin
            tick;
            n++;
        end
        chk("beat_wait", 256'(beats_seen >= target), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        #3;
        chk("rst_desc_ready", 256'(desc_ready), 256'(0));
        chk("rst_avm_write", 256'(avm_write), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_addr_bc", 256'({avm_address, avm_burstcount}), 256'(0));
        chk("rst_busy_done", 256'({busy, done}), 256'(0));
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        chk("desc_ready_after_rst", 256'(desc_ready), 256'(1));

        // 1: single 4-beat burst, 4 beats left behind in the FIFO
        push_beats(8);
        send_desc(32'h1000, 24'd128);
        wait_done(50, "t1_done");
        chk("t1_fill_left", 256'(fill_level), 256'(4));

        // 2: 5 beats split into 4 @0x2000 and 1 @0x2080
        push_beats(1);
        send_desc(32'h2000, 24'd160);
        wait_done(50, "t2_done");
        chk("t2_fifo_empty", 256'(fill_level), 256'(0));

        // 3: waitrequest stall on beat 2
        push_beats(4);
        b0 = beats_seen;
        send_desc(32'h3000, 24'd128);
        wait_beats(b0 + 1);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_write", 256'(avm_write), 256'(1));
            chk("t3_stall_nopop", 256'(in_ready), 256'(0));
            chk("t3_stall_addr", 256'(avm_address), 256'(32'h3000));
            chk("t3_stall_data", avm_writedata, exp_q[0].data);
            chk("t3_stall_fill", 256'(fill_level), 256'(3));
        end
        @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_done(50, "t3_done");
        chk("t3_beats", 256'(beats_seen - b0), 256'(4));

        // 4: zero length, then sub-beat length rounding down to one beat
        b0 = beats_seen;
        send_desc(32'h0, 24'd0);
        wait_done(2, "t4_len0_done");
        chk("t4_len0_nowrite", 256'(beats_seen), 256'(b0));
        push_beats(1);
        send_desc(32'h4000, 24'h3F);
        wait_done(50, "t4_len3f_done");
        chk("t4_len3f_beats", 256'(beats_seen - b0), 256'(1));

        // 5: burst held off until fill covers it
        push_beats(2);
        send_desc(32'h5000, 24'd128);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_hold", 256'({avm_write, busy}), 256'(2'b01));
        end
        @(posedge clk);
        #1;
        push_beats(2);
        @(negedge clk);
        chk("t5_still_wait", 256'(avm_write), 256'(0));
        @(negedge clk);
        chk("t5_start", 256'({avm_write, avm_burstcount}), 256'({1'b1, 3'd4}));
        wait_done(50, "t5_done");

        // 6: reset after beat 2, then a fresh descriptor
        push_beats(4);
        b0 = beats_seen;
        send_desc(32'h6000, 24'd128);
        wait_beats(b0 + 2);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_write", 256'({avm_write, in_ready}), 256'(0));
        chk("t6_rst_status", 256'({desc_ready, busy, done}), 256'(0));
        chk("t6_rst_addr_bc", 256'({avm_address, avm_burstcount}), 256'(0));
        tick;
        fifo.delete();
        exp_q.delete();
        claim_idx = push_idx;
        tick;
        reset_n = 1'b1;
        tick;
        chk("t6_ready_again", 256'(desc_ready), 256'(1));
        push_beats(4);
        b0 = beats_seen;
        send_desc(32'h7000, 24'd128);
        wait_done(50, "t6_new_done");
        chk("t6_new_beats", 256'(beats_seen - b0), 256'(4));

        n = exp_q.size();
        chk("scoreboard_empty", 256'(n), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
